vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 67 ++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA pixel/line counters, syncs, blanking and frame strobes
module vga_timing_gen #(
    parameter int CLKDIV    = 1,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] xpos_vga,
    output logic [9:0] ypos_vga,
    output logic       vidactive,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       frame_done
);
    localparam int DW = CLKDIV > 1 ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
    localparam logic [9:0] HS0 = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS1 = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS0 = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS1 = 10'(V_VISIBLE + V_FP + V_SYNC);
    logic [DW-1:0] div, div_n;
    logic [9:0] h_n, v_n;
    logic line_end;
    always_comb begin
        div_n    = (div == DIV_LAST) ? '0 : div + 1'b1;
        line_end = pix_tick && (xpos_vga == H_LAST);
        h_n      = pix_tick ? (line_end ? '0 : xpos_vga + 1'b1) : xpos_vga;
        v_n      = line_end ? ((ypos_vga == V_LAST) ? '0 : ypos_vga + 1'b1) : ypos_vga;
    end
    // decoded outputs come from next-state counters so they line up with xpos/ypos
    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            pix_tick    <= 1'b0;
            xpos_vga    <= H_LAST;
            ypos_vga    <= V_LAST;
            vidactive   <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            div         <= div_n;
            pix_tick    <= (div_n == DIV_LAST);
            xpos_vga    <= h_n;
            ypos_vga    <= v_n;
            vidactive   <= (h_n < H_VIS) && (v_n < V_VIS);
            hsync       <= !((h_n >= HS0) && (h_n < HS1));
            vsync       <= !((v_n >= VS0) && (v_n < VS1));
            frame_start <= pix_tick && (h_n == '0) && (v_n == '0);
            frame_done  <= pix_tick && (h_n == '0) && (v_n == V_VIS);
        end
    end
endmodule
